instr_fetch_unit: RTL and testbench

//  Initiator side of the instruction-memory read interface. Holds the PC and drives imem_addr.

---
 rtl/ifu_pkg.sv | 20 ++
 rtl/ifu_if.sv | 27 ++
 rtl/ifu_out_stage.sv | 45 ++++
 rtl/instr_fetch_unit.sv | 92 +++++++++
 tb/tb_instr_fetch_unit.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Also used by the optional zero-word stop feature (IFU_ZERO_STOP_EN).
package ifu_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] PC_STEP    = 32'd4;
  localparam logic [XLEN-1:0] ALIGN_MASK = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } ifu_state_e;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & ALIGN_MASK;
  endfunction

endpackage

// File: rtl/ifu_if.sv
// Control, instruction-memory and decode-handshake signals of the fetch unit.
// The master side is the fetch unit; the slave side is its environment.
interface ifu_if;
  import ifu_pkg::*;

  logic            start;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_rdata;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_instr;
  logic [XLEN-1:0] out_pc;
  logic            done;

  modport master (
    input  start, redirect, redirect_pc, imem_rdata, out_ready,
    output imem_addr, out_valid, out_instr, out_pc, done
  );

  modport slave (
    output start, redirect, redirect_pc, imem_rdata, out_ready,
    input  imem_addr, out_valid, out_instr, out_pc, done
  );

endinterface

// File: rtl/ifu_out_stage.sv
// Valid/ready output register holding one fetched {pc, instr} pair for decode.
// Flush wins over load; an accepted entry clears unless a new one replaces it.
module ifu_out_stage
  import ifu_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            i_load,
  input  logic            i_flush,
  input  logic            i_ready,
  input  logic [XLEN-1:0] i_instr,
  input  logic [XLEN-1:0] i_pc,
  output logic            o_valid,
  output logic [XLEN-1:0] o_instr,
  output logic [XLEN-1:0] o_pc,
  output logic            o_advance
);

  logic            r_valid;
  logic [XLEN-1:0] r_instr;
  logic [XLEN-1:0] r_pc;

  assign o_advance = !r_valid || i_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_instr <= '0;
      r_pc    <= '0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_instr <= i_instr;
      r_pc    <= i_pc;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_instr = r_instr;
  assign o_pc    = r_pc;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: PC, IDLE/RUN/DRAIN/DONE sequencing and redirect handling.
// Define IFU_ZERO_STOP_EN to treat a fetched all-zero word as end of program.
module instr_fetch_unit
  import ifu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0,
  parameter int              IMEM_WORDS = 16
) (
  input logic   clk,
  input logic   rst,
  ifu_if.master ifu
);

  localparam logic [XLEN-1:0] PC_LIMIT = XLEN'(IMEM_WORDS * 4);

  ifu_state_e      r_state;
  ifu_state_e      w_state_next;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc_next;
  logic            w_load;
  logic            w_flush;
  logic            w_advance;
  logic            w_stop;

`ifdef IFU_ZERO_STOP_EN
  assign w_stop = (r_pc >= PC_LIMIT) || (ifu.imem_rdata == '0);
`else
  assign w_stop = (r_pc >= PC_LIMIT);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_pc    <= RESET_PC;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
    end
  end

  // Redirect outranks everything except while IDLE, where it is ignored.
  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_load       = 1'b0;
    w_flush      = 1'b0;
    if (ifu.redirect && (r_state != IDLE)) begin
      w_flush      = 1'b1;
      w_pc_next    = word_align(ifu.redirect_pc);
      w_state_next = RUN;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (ifu.start) w_state_next = RUN;
        end
        RUN: begin
          if (w_stop) begin
            w_state_next = DRAIN;
          end else if (w_advance) begin
            w_load    = 1'b1;
            w_pc_next = r_pc + PC_STEP;
          end
        end
        DRAIN: begin
          if (w_advance) w_state_next = DONE;
        end
        DONE: begin
          w_state_next = DONE;
        end
        default: w_state_next = IDLE;
      endcase
    end
  end

  ifu_out_stage u_out_stage (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_load),
    .i_flush   (w_flush),
    .i_ready   (ifu.out_ready),
    .i_instr   (ifu.imem_rdata),
    .i_pc      (r_pc),
    .o_valid   (ifu.out_valid),
    .o_instr   (ifu.out_instr),
    .o_pc      (ifu.out_pc),
    .o_advance (w_advance)
  );

  assign ifu.imem_addr = r_pc;
  assign ifu.done      = (r_state == DONE);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a 16-word combinational memory model.
// Build with IFU_ZERO_STOP_EN defined to exercise the zero-word stop variant.
module tb_instr_fetch_unit;
  import ifu_pkg::*;

  logic clk;
  logic rst;
  ifu_if ifu_bus ();

  logic [31:0] mem [16];
  int n_checks;
  int n_fail;

  instr_fetch_unit #(.RESET_PC(32'h0), .IMEM_WORDS(16)) dut (
    .clk (clk),
    .rst (rst),
    .ifu (ifu_bus)
  );

  assign ifu_bus.imem_rdata = (ifu_bus.imem_addr < 32'd64) ? mem[ifu_bus.imem_addr[5:2]] : 32'h0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ifu_bus.start       = 1'b0;
    ifu_bus.redirect    = 1'b0;
    ifu_bus.redirect_pc = 32'h0;
    ifu_bus.out_ready   = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Returns at the negedge after the start cycle; the first capture happens at the next edge.
  task automatic start_run();
    ifu_bus.start = 1'b1;
    @(negedge clk);
    ifu_bus.start = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    mem[0] = 32'h003100B3;
    mem[1] = 32'h00308233;
    mem[2] = 32'h401202B3;
    mem[3] = 32'h00528313;
    mem[4] = 32'h00331393;
    for (int i = 5; i < 16; i++) mem[i] = 32'h1000_0013 + 32'(i);

    rst = 1'b1;
    ifu_bus.start       = 1'b0;
    ifu_bus.redirect    = 1'b0;
    ifu_bus.redirect_pc = 32'h0;
    ifu_bus.out_ready   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_valid", 32'(ifu_bus.out_valid), 32'h0);
    check("rst_instr", ifu_bus.out_instr, 32'h0);
    check("rst_pc", ifu_bus.out_pc, 32'h0);
    check("rst_done", 32'(ifu_bus.done), 32'h0);
    check("rst_addr", ifu_bus.imem_addr, 32'h0);
    rst = 1'b0;
    ifu_bus.redirect = 1'b1;
    ifu_bus.redirect_pc = 32'h20;
    @(negedge clk);
    ifu_bus.redirect = 1'b0;
    check("idle_redirect_ignored", ifu_bus.imem_addr, 32'h0);
    @(negedge clk);
    check("idle_no_fetch", 32'(ifu_bus.out_valid), 32'h0);

    // T1 streaming
    ifu_bus.out_ready = 1'b1;
    start_run();
    check("t1_latency", 32'(ifu_bus.out_valid), 32'h0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t1_valid", 32'(ifu_bus.out_valid), 32'h1);
      check("t1_pc", ifu_bus.out_pc, 32'(i * 4));
      check("t1_instr", ifu_bus.out_instr, mem[i]);
    end

    // T2 backpressure at out_pc=4
    do_reset();
    ifu_bus.out_ready = 1'b1;
    start_run();
    @(negedge clk);
    check("t2_pc0", ifu_bus.out_pc, 32'h0);
    @(negedge clk);
    check("t2_pc4", ifu_bus.out_pc, 32'h4);
    ifu_bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t2_hold_valid", 32'(ifu_bus.out_valid), 32'h1);
      check("t2_hold_pc", ifu_bus.out_pc, 32'h4);
      check("t2_hold_instr", ifu_bus.out_instr, 32'h00308233);
      check("t2_hold_addr", ifu_bus.imem_addr, 32'h8);
    end
    ifu_bus.out_ready = 1'b1;
    @(negedge clk);
    check("t2_resume_pc", ifu_bus.out_pc, 32'h8);
    check("t2_resume_instr", ifu_bus.out_instr, 32'h401202B3);
    @(negedge clk);
    check("t2_next_pc", ifu_bus.out_pc, 32'hC);

    // T3 redirect during stall
    do_reset();
    ifu_bus.out_ready = 1'b1;
    start_run();
    @(negedge clk);
    @(negedge clk);
    ifu_bus.out_ready = 1'b0;
    check("t3_stall_pc", ifu_bus.out_pc, 32'h4);
    ifu_bus.redirect    = 1'b1;
    ifu_bus.redirect_pc = 32'h0000_000E;
    @(negedge clk);
    ifu_bus.redirect = 1'b0;
    check("t3_flush_valid", 32'(ifu_bus.out_valid), 32'h0);
    check("t3_aligned_addr", ifu_bus.imem_addr, 32'hC);
    ifu_bus.out_ready = 1'b1;
    @(negedge clk);
    check("t3_target_valid", 32'(ifu_bus.out_valid), 32'h1);
    check("t3_target_pc", ifu_bus.out_pc, 32'hC);
    check("t3_target_instr", ifu_bus.out_instr, 32'h00528313);

    // T4 end of range
    do_reset();
    ifu_bus.out_ready = 1'b1;
    start_run();
    repeat (16) @(negedge clk);
    check("t4_last_pc", ifu_bus.out_pc, 32'h3C);
    ifu_bus.out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("t4_drain_valid", 32'(ifu_bus.out_valid), 32'h1);
      check("t4_drain_pc", ifu_bus.out_pc, 32'h3C);
      check("t4_drain_done", 32'(ifu_bus.done), 32'h0);
    end
    ifu_bus.out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("t4_done", 32'(ifu_bus.done), 32'h1);
      check("t4_done_valid", 32'(ifu_bus.out_valid), 32'h0);
      check("t4_done_addr", ifu_bus.imem_addr, 32'h40);
    end
    ifu_bus.redirect    = 1'b1;
    ifu_bus.redirect_pc = 32'h100;
    @(negedge clk);
    ifu_bus.redirect = 1'b0;
    check("t4_redir_run", 32'(ifu_bus.done), 32'h0);
    @(negedge clk);
    @(negedge clk);
    check("t4_redir_done", 32'(ifu_bus.done), 32'h1);
    check("t4_redir_valid", 32'(ifu_bus.out_valid), 32'h0);

    // T5 async reset mid-run
    do_reset();
    ifu_bus.out_ready = 1'b1;
    start_run();
    @(negedge clk);
    @(negedge clk);
    check("t5_running", ifu_bus.out_pc, 32'h4);
    #2;
    rst = 1'b1;
    #1;
    check("t5_async_valid", 32'(ifu_bus.out_valid), 32'h0);
    check("t5_async_addr", ifu_bus.imem_addr, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("t5_idle", 32'(ifu_bus.out_valid), 32'h0);
    start_run();
    @(negedge clk);
    check("t5_restart_pc", ifu_bus.out_pc, 32'h0);
    check("t5_restart_valid", 32'(ifu_bus.out_valid), 32'h1);

    // T6 zero word at index 5
    do_reset();
    mem[5] = 32'h0;
    ifu_bus.out_ready = 1'b1;
    start_run();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t6_pc", ifu_bus.out_pc, 32'(i * 4));
    end
    @(negedge clk);
`ifdef IFU_ZERO_STOP_EN
    check("t6_stop_valid", 32'(ifu_bus.out_valid), 32'h0);
    check("t6_stop_addr", ifu_bus.imem_addr, 32'h14);
    @(negedge clk);
    check("t6_stop_done", 32'(ifu_bus.done), 32'h1);
`else
    check("t6_zero_valid", 32'(ifu_bus.out_valid), 32'h1);
    check("t6_zero_pc", ifu_bus.out_pc, 32'h14);
    check("t6_zero_instr", ifu_bus.out_instr, 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
